// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: shared opcodes, state encoding and binary16 constants for the vector ALU sequencer
package vec_alu_pkg;
    localparam int LANES = 16;
    localparam int FW    = 16;

    localparam logic [3:0] VADD = 4'b0000;
    localparam logic [3:0] VDOT = 4'b0001;
    localparam logic [3:0] SMUL = 4'b0010;
    localparam logic [3:0] SST  = 4'b0011;
    localparam logic [3:0] VLD  = 4'b0100;
    localparam logic [3:0] VST  = 4'b0101;
    localparam logic [3:0] SLL  = 4'b0110;
    localparam logic [3:0] SLH  = 4'b0111;
    localparam logic [3:0] J    = 4'b1000;
    localparam logic [3:0] NOP  = 4'b1111;

    localparam logic [FW-1:0] ONE  = 16'h3C00;
    localparam logic [FW-1:0] MAXF = 16'h7BFF;
    localparam logic [FW-1:0] ZERO = 16'h0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fp16_lane.sv
// fp16_lane: combinational binary16 add / mul / mul-then-add lane, round toward zero, flush-to-zero, saturating
module fp16_lane
    import vec_alu_pkg::*;
(
    input  logic [FW-1:0] a,
    input  logic [FW-1:0] b,
    input  logic          sel_mul,
    input  logic [FW-1:0] acc_in,
    input  logic          mode_dot,
    output logic [FW-1:0] r
);
    function automatic logic [FW-1:0] cln(input logic [FW-1:0] x);
        return (x[14:10] == 5'd31) ? {x[15], MAXF[14:0]} : (x[14:10] == 5'd0) ? {x[15], ZERO[14:0]} : x;
    endfunction

    function automatic logic [FW-1:0] pack(input logic s, input logic signed [7:0] e, input logic [9:0] m);
        return (e > 8'sd30) ? {s, MAXF[14:0]} : (e < 8'sd1) ? {s, ZERO[14:0]} : {s, e[4:0], m};
    endfunction

    function automatic logic [FW-1:0] fmul(input logic [FW-1:0] x, input logic [FW-1:0] y);
        logic [FW-1:0] p, q;
        logic [21:0] m;
        logic signed [7:0] e;
        p = cln(x);
        q = cln(y);
        if (p[14:10] == 5'd0 || q[14:10] == 5'd0) return {p[15] ^ q[15], ZERO[14:0]};
        m = 22'({1'b1, p[9:0]}) * 22'({1'b1, q[9:0]});
        e = 8'(p[14:10]) + 8'(q[14:10]) - 8'd15 + 8'(m[21]);
        return pack(p[15] ^ q[15], e, m[21] ? m[20:11] : m[19:10]);
    endfunction

    // Smaller operand is aligned into a 43-bit field wide enough to keep every
    // shifted-out bit, so truncating the exact sum gives round-toward-zero.
    function automatic logic [FW-1:0] fadd(input logic [FW-1:0] x, input logic [FW-1:0] y);
        logic [FW-1:0] p, q, g, l;
        logic [42:0] s, t;
        logic [5:0] h;
        logic signed [7:0] e;
        p = cln(x);
        q = cln(y);
        g = (p[14:0] >= q[14:0]) ? p : q;
        l = (p[14:0] >= q[14:0]) ? q : p;
        if (l[14:10] == 5'd0) return g;
        t = {2'b01, l[9:0], 31'd0} >> (g[14:10] - l[14:10]);
        s = (g[15] == l[15]) ? {2'b01, g[9:0], 31'd0} + t : {2'b01, g[9:0], 31'd0} - t;
        if (s == '0) return ZERO;
        h = '0;
        for (int i = 0; i < 43; i++) if (s[i]) h = 6'(i);
        t = s << (6'd42 - h);
        e = 8'(g[14:10]) + 8'(h) - 8'd41;
        return pack(g[15], e, t[41:32]);
    endfunction

    always_comb begin
        r = mode_dot ? fadd(acc_in, fmul(a, b)) : sel_mul ? fmul(a, b) : fadd(a, b);
    end
endmodule

// File: rtl/vec_alu_seq.sv
// vec_alu_seq: steps one shared fp16 lane across 16 lanes of a 256-bit vector op behind valid/ready handshakes
module vec_alu_seq
    import vec_alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_opcode,
    input  logic [LANES*FW-1:0] in_op_1,
    input  logic [LANES*FW-1:0] in_op_2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*FW-1:0] out_result,
    output logic                out_err,
    output logic                busy
);
    state_t state, nxt;
    logic [3:0] cnt, opc;
    logic [LANES*FW-1:0] op_a, op_b, res;
    logic [FW-1:0] acc, lane_a, lane_b, lane_r;
    logic err, is_alu, take;

    assign is_alu = in_opcode == VADD || in_opcode == VDOT || in_opcode == SMUL;
    assign take   = state == IDLE && in_valid;
    assign lane_a = opc == SMUL ? op_a[FW-1:0] : op_a[{cnt, 4'd0} +: FW];
    assign lane_b = op_b[{cnt, 4'd0} +: FW];

    fp16_lane u_lane (
        .a        (lane_a),
        .b        (lane_b),
        .sel_mul  (opc == SMUL),
        .acc_in   (acc),
        .mode_dot (opc == VDOT),
        .r        (lane_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (take) nxt = is_alu ? RUN : DONE;
        if (state == RUN && cnt == 4'd15) nxt = DONE;
        if (state == DONE && out_ready) nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            opc  <= VADD;
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            acc  <= ZERO;
            err  <= 1'b0;
        end else if (take) begin
            cnt  <= '0;
            opc  <= in_opcode;
            op_a <= in_op_1;
            op_b <= in_op_2;
            res  <= '0;
            acc  <= ZERO;
            err  <= !is_alu && in_opcode != NOP;
        end else if (state == RUN) begin
            cnt <= cnt + 4'd1;
            if (opc == VDOT) acc <= lane_r;
            else             res[{cnt, 4'd0} +: FW] <= lane_r;
        end
    end

    assign in_ready   = state == IDLE && !rst;
    assign out_valid  = state == DONE;
    assign busy       = state != IDLE;
    assign out_err    = err;
    assign out_result = opc == VDOT ? {{(LANES-1)*FW{1'b0}}, acc} : res;
endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: directed self-checking bench for the lane-serial vector ALU sequencer
module tb_vec_alu_seq;
    import vec_alu_pkg::*;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [3:0] in_opcode;
    logic [255:0] in_op_1, in_op_2, out_result;
    logic [255:0] va, vb, ve;
    int checks = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    vec_alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_op_1    (in_op_1),
        .in_op_2    (in_op_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b);
        in_opcode = op;
        in_op_1 = a;
        in_op_2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 256'(in_ready), 256'(1));
        chk({tag, "_valid_dropped"}, 256'(out_valid), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_opcode = VADD;
        in_op_1 = '0;
        in_op_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_result", out_result, 256'(0));
        chk("rst_out_err", 256'(out_err), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;

        // VADD 1.0 + 1.0 on every lane
        issue(VADD, {16{16'h3C00}}, {16{16'h3C00}});
        chk("vadd_latency", 256'(lat), 256'(17));
        chk("vadd_result", out_result, {16{16'h4000}});
        chk("vadd_err", 256'(out_err), 256'(0));
        accept("vadd");

        // SMUL: scalar 2.0 times 1.0, -3.0, 0.0 repeating
        va = {{15{16'h1234}}, 16'h4000};
        for (int i = 0; i < 16; i++) begin
            vb[16*i +: 16] = (i % 3 == 0) ? 16'h3C00 : (i % 3 == 1) ? 16'hC200 : 16'h0000;
            ve[16*i +: 16] = (i % 3 == 0) ? 16'h4000 : (i % 3 == 1) ? 16'hC600 : 16'h0000;
        end
        issue(SMUL, va, vb);
        chk("smul_latency", 256'(lat), 256'(17));
        chk("smul_result", out_result, ve);
        accept("smul");

        // VDOT of sixteen 1.0 * 1.0 products = 16.0
        issue(VDOT, {16{16'h3C00}}, {16{16'h3C00}});
        chk("vdot_result", out_result, {240'd0, 16'h4C00});
        chk("vdot_err", 256'(out_err), 256'(0));
        accept("vdot");

        // Boundary lanes: saturation, subnormal flush, cancellation, truncation, exp-31 input, signs
        va = '0;
        vb = '0;
        ve = '0;
        va[15:0]    = 16'h7BFF; vb[15:0]    = 16'h7BFF; ve[15:0]    = 16'h7BFF;
        va[31:16]   = 16'h0001; vb[31:16]   = 16'h0000; ve[31:16]   = 16'h0000;
        va[47:32]   = 16'h3C00; vb[47:32]   = 16'hBC00; ve[47:32]   = 16'h0000;
        va[63:48]   = 16'h3C00; vb[63:48]   = 16'h8C00; ve[63:48]   = 16'h3BFF;
        va[79:64]   = 16'h7C00; vb[79:64]   = 16'h0000; ve[79:64]   = 16'h7BFF;
        va[95:80]   = 16'hC000; vb[95:80]   = 16'h4400; ve[95:80]   = 16'h4000;
        va[111:96]  = 16'hFBFF; vb[111:96]  = 16'hFBFF; ve[111:96]  = 16'hFBFF;
        va[127:112] = 16'h3C00; vb[127:112] = 16'h1000; ve[127:112] = 16'h3C00;
        issue(VADD, va, vb);
        chk("edge_result", out_result, ve);
        accept("edge");

        // Illegal opcode VLD, result held while out_ready stays low
        issue(VLD, {16{16'h3C00}}, {16{16'h3C00}});
        chk("vld_latency", 256'(lat), 256'(1));
        chk("vld_err", 256'(out_err), 256'(1));
        chk("vld_result", out_result, 256'(0));
        chk("vld_busy", 256'(busy), 256'(1));
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("vld_hold_valid", 256'(out_valid), 256'(1));
            chk("vld_hold_result", out_result, 256'(0));
            chk("vld_hold_err", 256'(out_err), 256'(1));
            chk("vld_hold_in_ready", 256'(in_ready), 256'(0));
        end
        accept("vld");

        issue(NOP, {16{16'h3C00}}, {16{16'h3C00}});
        chk("nop_latency", 256'(lat), 256'(1));
        chk("nop_err", 256'(out_err), 256'(0));
        chk("nop_result", out_result, 256'(0));
        accept("nop");

        // Reset while processing lane 7
        in_opcode = VADD;
        in_op_1 = {16{16'h3C00}};
        in_op_2 = {16{16'h3C00}};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_run_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
        chk("mid_rst_result", out_result, 256'(0));
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));
        issue(VADD, {16{16'h4000}}, {16{16'h3C00}});
        chk("post_rst_latency", 256'(lat), 256'(17));
        chk("post_rst_result", out_result, {16{16'h4200}});
        accept("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vec_alu_seq.md
# vec_alu_seq

Lane-serial sequencer for the vector ALU opcodes: accepts one 256-bit vector operation (16 × binary16 lanes) per valid/ready handshake and steps a single shared half-precision lane unit across the 16 lanes, one lane per cycle. It assembles the 256-bit result and presents it on a valid/ready output. It sits between instruction decode and the register-file write port, and replaces 16 parallel FP adders with one add/multiply lane.

## Interface
- LANES, 16, lanes per vector.
- FW, 16, lane float width (binary16).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept; high only in IDLE and while rst low.
- in_opcode  in  4  opcode (VADD 0000, VDOT 0001, SMUL 0010, NOP 1111; others illegal here).
- in_op_1, in_op_2  in  256  operands; lane i = bits [16i+15:16i].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_result  out  256  result vector.
- out_err  out  1  opcode was not an ALU op; qualified by out_valid.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_valid & in_ready latches opcode, op_1, op_2; clears lane counter, accumulator and result register.
  - VADD/VDOT/SMUL → RUN.
  - NOP → DONE, result 0, err 0.
  - Any other opcode (SST, VLD, VST, SLL, SLH, J, 1001–1110) → DONE, result 0, err 1.
- RUN: counter cnt (4 bits) selects lane cnt, processing 0 → 15.
  - VADD: result[cnt] = add(a[cnt], b[cnt]).
  - SMUL: result[cnt] = mul(a[0], b[cnt]); op_1 lane 0 is the scalar.
  - VDOT: acc = add(acc, mul(a[cnt], b[cnt])). The 16-bit acc starts at 0x0000.
  - At cnt == 15: the lane write completes, then → DONE. cnt wraps to 0; no other wrap behaviour.
- DONE: out_valid = 1. For VDOT, out_result = {240'b0, acc}. out_valid & out_ready → IDLE. Result and err hold stable while waiting.
- fp16_lane arithmetic:
  - IEEE binary16 with hidden bit and bias 15.
  - Round toward zero.
  - Subnormal inputs and results flush to signed zero.
  - Overflow saturates to ±0x7BFF.
  - Exponent-31 inputs are treated as ±0x7BFF.
  - Exact cancellation yields +0x0000.
- No operation overlap. Inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_err 0, busy 0, in_ready 0 while rst high, cnt 0, acc 0.
- Handshake in cycle T (ALU op): RUN covers cycles T+1..T+16. out_valid rises at T+17.
- Handshake in cycle T (NOP/illegal): out_valid rises at T+1.
- Output accepted in cycle D: in_ready = 1 at D+1. Back-to-back ALU ops therefore sustain one op per 18 cycles with out_ready tied high.
- in_valid without in_ready: no effect. Requester holds its data.
- rst asserted mid-RUN or in DONE: immediate return to IDLE with reset values. The partial result is discarded and out_valid drops asynchronously.
- out_ready while out_valid is low: ignored.

## Structure
- Package vec_alu_pkg holds:
  - opcode constants (VADD, VDOT, SMUL, SST, VLD, VST, SLL, SLH, J, NOP);
  - the state enum;
  - LANES and FW;
  - FP16 constants ONE = 0x3C00, MAXF = 0x7BFF, ZERO = 0x0000.
- Sub-module fp16_lane: purely combinational, with inputs a, b, sel_mul, acc_in, mode_dot and output r. It implements add, mul and fused-sequence mul-then-add (two rounding steps). This is the only arithmetic in the block.
- The sequencer owns all registers: state, cnt, operand latches, result, acc, err.

## Test plan
- VADD, all lanes 0x3C00 + 0x3C00 → out_result = 16 × 0x4000, err 0, out_valid exactly 17 cycles after handshake.
- SMUL, op_1 lane 0 = 0x4000, op_2 lanes = 0x3C00, 0xC200, 0x0000 repeating → lanes 0x4000, 0xC600, 0x0000.
- VDOT, all lanes 0x3C00 · 0x3C00 → out_result[15:0] = 0x4C00 (16.0), upper 240 bits 0.
- Saturation: VADD 0x7BFF + 0x7BFF → 0x7BFF. Subnormal 0x0001 + 0x0000 → 0x0000.
- Opcode VLD → out_valid at T+1, err 1, result 0. With out_ready held low for 5 cycles, out_valid and result stay stable and in_ready stays 0.
- rst pulsed at RUN lane 7 → out_valid 0 and busy 0 immediately. in_ready returns after deassert. The next VADD produces a correct full result.
